// File: rtl/fetch_11.sv
// fetch_11 -- instruction fetch unit for the single-cycle datapath.
//
// Owns the fetch program counter, issues one word read at a time to
// instruction memory over a req/ack handshake, buffers the returned words
// in a small prefetch FIFO and hands them to the datapath with a
// valid/ready handshake. A taken branch/jump (i_salto) flushes the FIFO
// and redirects fetch; a read already in flight is completed and dropped.
//
// Parameters:
//   RESET_PC  first fetch address after reset (word aligned)
//   DEPTH     prefetch FIFO entries, 2..8
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   o_imem_req/o_imem_addr  read request and word-aligned byte address
//   i_imem_ack/i_imem_data  read completion and returned word
//   o_codigo/o_pc           instruction at the FIFO head and its address
//   o_valido/i_listo        head valid / datapath accepts head
//   i_salto/i_dest          redirect pulse and target (bits [1:0] ignored)

module fetch_11 #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_data,
    output logic [31:0] o_codigo,
    output logic [31:0] o_pc,
    output logic        o_valido,
    input  logic        i_listo,
    input  logic        i_salto,
    input  logic [31:0] i_dest
);

    localparam int            CW   = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        REPOSO    = 2'd0,   // no request outstanding
        PEDIR     = 2'd1,   // request outstanding, data will be kept
        DESCARTAR = 2'd2    // request outstanding, data will be dropped
    } state_t;

    state_t        state_reg, state_next;
    logic [31:0]   fpc_reg, fpc_next;
    logic [31:0]   fpc_pend_reg, fpc_pend_next;
    logic [CW-1:0] count_reg, count_next;
    logic [CW-1:0] wr_idx;
    logic          pop;
    logic          push;
    logic [31:0]   dest_aligned;

    // Per-entry register contents, entry 0 is the head.
    logic [31:0]   ent_pc    [DEPTH];
    logic [31:0]   ent_instr [DEPTH];

    assign dest_aligned = i_dest & 32'hFFFF_FFFC;
    assign pop          = (count_reg != '0) && i_listo;
    // A redirect in the same cycle as the ack turns the returned word stale.
    assign push         = (state_reg == PEDIR) && i_imem_ack && !i_salto;
    // With a simultaneous pop everything shifts down one slot first.
    assign wr_idx       = count_reg - CW'(pop);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg    <= REPOSO;
            fpc_reg      <= RESET_PC;
            fpc_pend_reg <= RESET_PC;
            count_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            fpc_reg      <= fpc_next;
            fpc_pend_reg <= fpc_pend_next;
            count_reg    <= count_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        fpc_next      = fpc_reg;
        fpc_pend_next = fpc_pend_reg;
        // A flush wins over any same-cycle pop or push.
        if (i_salto) begin
            count_next = '0;
        end else begin
            count_next = count_reg + CW'(push) - CW'(pop);
        end

        case (state_reg)
            REPOSO: begin
                if (i_salto) begin
                    fpc_next   = dest_aligned;
                    state_next = PEDIR;
                end else if (count_next < FULL) begin
                    state_next = PEDIR;
                end
            end
            PEDIR: begin
                if (i_imem_ack) begin
                    if (i_salto) begin
                        fpc_next = dest_aligned;
                    end else begin
                        // 32-bit add wraps 0xFFFF_FFFC back to 0.
                        fpc_next = fpc_reg + 32'd4;
                        if (count_next >= FULL) begin
                            state_next = REPOSO;
                        end
                    end
                end else if (i_salto) begin
                    // The request cannot be withdrawn: keep fpc on the
                    // address being driven and park the target.
                    fpc_pend_next = dest_aligned;
                    state_next    = DESCARTAR;
                end
            end
            DESCARTAR: begin
                if (i_salto) begin
                    fpc_pend_next = dest_aligned;
                end
                if (i_imem_ack) begin
                    fpc_next   = i_salto ? dest_aligned : fpc_pend_reg;
                    state_next = PEDIR;
                end
            end
            default: begin
                state_next = REPOSO;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from registers only
    // ------------------------------------------------------------------
    always_comb begin
        o_imem_req  = (state_reg != REPOSO);
        o_imem_addr = fpc_reg;
        o_valido    = (count_reg != '0);
        o_codigo    = ent_instr[0];
        o_pc        = ent_pc[0];
    end

    // ------------------------------------------------------------------
    // Prefetch FIFO as a shift register so the head is always slot 0.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [31:0] pc_reg;
            logic [31:0] instr_reg;
            logic [31:0] pc_shift;
            logic [31:0] instr_shift;

            if (gi == DEPTH - 1) begin : g_last
                assign pc_shift    = pc_reg;
                assign instr_shift = instr_reg;
            end else begin : g_mid
                assign pc_shift    = ent_pc[gi + 1];
                assign instr_shift = ent_instr[gi + 1];
            end

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    pc_reg    <= RESET_PC;
                    instr_reg <= '0;
                end else if (push && (wr_idx == CW'(gi))) begin
                    pc_reg    <= fpc_reg;
                    instr_reg <= i_imem_data;
                end else if (pop) begin
                    pc_reg    <= pc_shift;
                    instr_reg <= instr_shift;
                end
            end

            assign ent_pc[gi]    = pc_reg;
            assign ent_instr[gi] = instr_reg;
        end
    endgenerate

endmodule

// File: tb/tb_fetch_11.sv
// Scoreboarded bench for fetch_11: a behavioural instruction memory with
// programmable ack delay returns addr ^ 32'hA5A5_A5A5; directed phases push
// the expected delivery order into a queue and a negedge monitor pops and
// compares each delivered instruction.

module tb_fetch_11;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] KEY    = 32'hA5A5_A5A5;

    logic        i_clk;
    logic        i_rst_n;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack;
    logic [31:0] i_imem_data;
    logic [31:0] o_codigo;
    logic [31:0] o_pc;
    logic        o_valido;
    logic        i_listo;
    logic        i_salto;
    logic [31:0] i_dest;

    fetch_11 #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .o_imem_req  (o_imem_req),
        .o_imem_addr (o_imem_addr),
        .i_imem_ack  (i_imem_ack),
        .i_imem_data (i_imem_data),
        .o_codigo    (o_codigo),
        .o_pc        (o_pc),
        .o_valido    (o_valido),
        .i_listo     (i_listo),
        .i_salto     (i_salto),
        .i_dest      (i_dest)
    );

    int          n_vec  = 0;
    int          n_miss = 0;
    int          cyc    = 0;
    int          mem_delay = 0;
    int          ack_count = 0;
    bit          ack_in_reset = 0;
    int          ack_cycles[$];
    logic [31:0] exp_q[$];

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        forever begin
            @(posedge i_clk);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end else begin
            $display("ok   %s: %h", nm, act);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    // Instruction memory: decides ack for the current cycle 1 time unit
    // after each rising edge, once the registered request is stable.
    initial begin
        int wait_cnt;
        wait_cnt    = 0;
        i_imem_ack  = 1'b0;
        i_imem_data = '0;
        forever begin
            @(posedge i_clk);
            #1;
            i_imem_ack = 1'b0;
            if (!i_rst_n) begin
                wait_cnt = 0;
                if (ack_in_reset) begin
                    i_imem_ack  = 1'b1;
                    i_imem_data = 32'hDEAD_BEEF;
                end
            end else if (o_imem_req) begin
                if (wait_cnt >= mem_delay) begin
                    i_imem_ack  = 1'b1;
                    i_imem_data = o_imem_addr ^ KEY;
                    wait_cnt    = 0;
                    ack_count++;
                    ack_cycles.push_back(cyc);
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: handshake stability and in-order delivery.
    initial begin
        bit          prev_hold;
        logic [31:0] prev_addr;
        logic [31:0] e;
        prev_hold = 0;
        prev_addr = '0;
        forever begin
            @(negedge i_clk);
            if (i_rst_n) begin
                if (prev_hold) begin
                    chk("req_held", {31'd0, o_imem_req}, 32'd1);
                    chk("addr_held", o_imem_addr, prev_addr);
                end
                prev_hold = o_imem_req && !i_imem_ack;
                prev_addr = o_imem_addr;
                if (o_valido && i_listo) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_miss++;
                        $display("FAIL unexpected_delivery: got pc %h, required no delivery", o_pc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("deliver_pc", o_pc, e);
                        chk("deliver_codigo", o_codigo, e ^ KEY);
                    end
                end
            end else begin
                prev_hold = 0;
            end
        end
    end

    task automatic drain(input string nm);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 400) begin
            tick();
            i++;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL %s: %0d instructions still outstanding, required 0", nm, exp_q.size());
            exp_q.delete();
        end else begin
            $display("ok   %s: all expected instructions delivered", nm);
        end
        i_listo = 1'b0;
    endtask

    task automatic assert_reset();
        i_listo = 1'b0;
        i_salto = 1'b0;
        i_dest  = '0;
        tick();
        i_rst_n = 1'b0;
        tick();
        tick();
        exp_q.delete();
        ack_cycles.delete();
        ack_count = 0;
    endtask

    // Release 1 unit after an edge; the cycle that follows is cycle 1.
    task automatic release_reset();
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    initial begin
        int k;
        i_rst_n = 1'b0;
        i_listo = 1'b0;
        i_salto = 1'b0;
        i_dest  = '0;

        // ---------------- reset values ----------------
        tick();
        tick();
        chk("rst_req", {31'd0, o_imem_req}, 32'd0);
        chk("rst_addr", o_imem_addr, RST_PC);
        chk("rst_valido", {31'd0, o_valido}, 32'd0);
        chk("rst_codigo", o_codigo, 32'd0);
        chk("rst_pc", o_pc, RST_PC);

        // ---------------- zero-wait streaming ----------------
        mem_delay = 0;
        for (int a = 0; a < 6; a++) exp_q.push_back(32'(a * 4));
        release_reset();
        #1;
        i_listo = 1'b1;
        chk("cycle1_req", {31'd0, o_imem_req}, 32'd0);
        tick();
        chk("cycle2_valido", {31'd0, o_valido}, 32'd0);
        for (k = 0; k < 5; k++) begin
            chk("stream_req", {31'd0, o_imem_req}, 32'd1);
            chk("stream_addr", o_imem_addr, 32'(k * 4));
            if (k == 1) chk("latency_valido", {31'd0, o_valido}, 32'd1);
            tick();
        end
        drain("stream_drain");

        // ---------------- backpressure ----------------
        assert_reset();
        mem_delay = 0;
        release_reset();
        repeat (10) tick();
        chk("bp_ack_count", 32'(ack_count), 32'd2);
        chk("bp_req_low", {31'd0, o_imem_req}, 32'd0);
        chk("bp_valido", {31'd0, o_valido}, 32'd1);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        exp_q.push_back(32'hC);
        i_listo = 1'b1;
        drain("bp_drain");

        // ---------------- 3-cycle ack delay ----------------
        assert_reset();
        mem_delay = 3;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        release_reset();
        i_listo = 1'b1;
        drain("slow_drain");
        n_vec++;
        if (ack_cycles.size() < 3) begin
            n_miss++;
            $display("FAIL slow_acks: got %0d acks, required at least 3", ack_cycles.size());
        end else begin
            n_vec--;
            chk("slow_interval0", 32'(ack_cycles[1] - ack_cycles[0]), 32'd4);
            chk("slow_interval1", 32'(ack_cycles[2] - ack_cycles[1]), 32'd4);
        end

        // ---------------- redirect while a read is pending ----------------
        assert_reset();
        mem_delay = 3;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        release_reset();
        i_listo = 1'b1;
        k = 0;
        while (!(o_imem_req && o_imem_addr == 32'h8) && k < 100) begin
            tick();
            k++;
        end
        chk("salto_wait_req8", {31'd0, o_imem_req && o_imem_addr == 32'h8}, 32'd1);
        i_salto = 1'b1;
        i_dest  = 32'h103;
        tick();
        i_salto = 1'b0;
        i_dest  = '0;
        chk("salto_flush_valido", {31'd0, o_valido}, 32'd0);
        chk("salto_old_addr", o_imem_addr, 32'h8);
        k = 0;
        while (o_imem_req && o_imem_addr == 32'h8 && k < 100) begin
            tick();
            k++;
        end
        chk("salto_new_req", {31'd0, o_imem_req}, 32'd1);
        chk("salto_new_addr", o_imem_addr, 32'h100);
        drain("salto_drain");

        // ---------------- fpc wrap ----------------
        assert_reset();
        mem_delay = 0;
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        release_reset();
        i_salto = 1'b1;
        i_dest  = 32'hFFFF_FFFC;
        i_listo = 1'b1;
        tick();
        i_salto = 1'b0;
        i_dest  = '0;
        chk("wrap_addr_top", o_imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_addr_zero", o_imem_addr, 32'h0);
        drain("wrap_drain");

        // ---------------- reset during a pending request ----------------
        assert_reset();
        mem_delay = 3;
        release_reset();
        k = 0;
        while (!(o_valido && o_imem_req) && k < 100) begin
            tick();
            k++;
        end
        chk("mid_pending", {31'd0, o_valido && o_imem_req}, 32'd1);
        i_rst_n = 1'b0;
        #1;
        chk("mid_async_req", {31'd0, o_imem_req}, 32'd0);
        chk("mid_async_valido", {31'd0, o_valido}, 32'd0);
        chk("mid_async_addr", o_imem_addr, RST_PC);
        ack_in_reset = 1'b1;
        tick();
        tick();
        chk("mid_ack_ignored", {31'd0, o_valido}, 32'd0);
        ack_in_reset = 1'b0;
        exp_q.delete();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        release_reset();
        #1;
        chk("mid_restart_cycle1", {31'd0, o_imem_req}, 32'd0);
        tick();
        chk("mid_restart_req", {31'd0, o_imem_req}, 32'd1);
        chk("mid_restart_addr", o_imem_addr, RST_PC);
        i_listo = 1'b1;
        drain("mid_drain");

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
